serial_receiver: RTL
====================

# serial_receiver

UART receive stage paired with `serial_transmitter`: it deserialises an 8N1 asynchronous line into bytes and buffers them in an internal FIFO. The read side exposes the same `rd_en`/`dout`/`valid`/`empty`/`data_count` handshake the transmitter's FIFO uses, so this block sits at the RX pin and feeds the byte-consuming logic (loopback, command parser) directly.

## Interface
- `CLK_IN`, 0: input clock frequency in Hz; must be set by the instantiator.
- `BAUD`, 0: line rate in bit/s; must be set by the instantiator.
- `DEPTH`, 512: FIFO depth in bytes; power of two, at least 2.
- Derived `BIT_CYCLES` = CLK_IN / BAUD, integer division, at least 4, at most 65535.
- Derived `HALF_CYCLES` = BIT_CYCLES / 2, integer division.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  asynchronous serial input; idle high.
- `rd_en`  in  1  pops the head byte on this edge when `valid`=1; ignored when empty.
- `dout`  out  8  head byte of the FIFO; 8'h00 when empty.
- `valid`  out  1  `!empty`.
- `empty`  out  1  FIFO holds 0 bytes.
- `full`  out  1  FIFO holds DEPTH bytes.
- `data_count`  out  $clog2(DEPTH)+1  bytes currently stored.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Input sync: `RX` passes through two flops to give `rx_s`. Both flops reset to 1.
- Bit counter: 16 bits. Reset to 0 on every state entry.
- Sample point: when counter reaches its target, the block samples `rx_s` and zeroes the counter. Otherwise the counter increments.
- State IDLE:
  - When `rx_s`=0, go to START.
- State START (target HALF_CYCLES-1):
  - If `rx_s`=0 at the sample point, go to DATA with `bit_idx`=0.
  - If `rx_s`=1, treat it as a glitch and return to IDLE. No flags are raised.
- State DATA (target BIT_CYCLES-1):
  - At each sample point, `shift_reg[bit_idx]` <= `rx_s`, so data is LSB first.
  - After bit 7, go to STOP.
- State STOP (target BIT_CYCLES-1), at the sample point:
  - `rx_s`=1 and push allowed: push `shift_reg`, go to IDLE.
  - `rx_s`=1 and push not allowed: pulse `overrun`, discard the byte, go to IDLE.
  - `rx_s`=0: pulse `frame_err`, discard the byte, go to BREAK.
- State BREAK:
  - Wait for `rx_s`=1, then go to IDLE.
  - A held-low line (break) therefore produces exactly one `frame_err`.
- Illegal or unused state encodings go to IDLE.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap naturally.
  - `data_count` is kept as a separate counter.
  - Push is allowed when `!full` or when a pop occurs in the same cycle.
  - Simultaneous push and pop: `data_count` is unchanged and order is preserved.
  - A pop when empty is a no-op, and `data_count` never underflows.
- Reset, asserted at any time including mid-frame:
  - Immediately: state IDLE, counter 0, `bit_idx` 0, `shift_reg` 0, pointers 0, `data_count` 0.
  - Outputs under reset: `empty`=1, `valid`=0, `full`=0, `dout`=8'h00, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - FIFO contents are lost. A partial frame is abandoned with no flags.

## Timing
- Sync latency: 2 cycles from a `RX` edge to the matching `rx_s` edge.
- Start sample: HALF_CYCLES cycles after IDLE detects `rx_s`=0.
- Each data sample and the stop sample: BIT_CYCLES cycles after the previous sample.
- Push edge: 2 + 1 + HALF_CYCLES + 9*BIT_CYCLES cycles after the `RX` falling edge, ±1.
- After the push edge:
  - `valid`, `dout` and `data_count` update on the same edge.
  - `dout` is combinational from the head pointer.
- Pop: the `rd_en` edge advances the head. The next byte, or 8'h00, appears the same cycle after the edge.
- `frame_err` and `overrun`: high for exactly the one cycle following the stop sample edge.
- `rx_busy`: rises the cycle after IDLE sees `rx_s`=0 and falls on entry to IDLE.
- Back-to-back frames are received with no idle gap beyond the stop bit.

## Test plan
Bench settings: CLK_IN=1_600_000 and BAUD=100_000, giving BIT_CYCLES=16. DEPTH=4 except where noted.
- Single byte: drive 8'hA5 in 8N1, no reads.
  - `valid`=1, `dout`=8'hA5, `data_count`=1.
  - Push edge within 2+1+8+144 cycles (±1) of the start edge.
  - No `frame_err`.
- Glitch: pulse `RX` low for 4 cycles.
  - No push, `rx_busy` returns low, `data_count` stays 0.
  - The next frame, 8'h5A, is received correctly.
- Framing error: send 8'h3C with the stop bit low, hold low 40 cycles, then idle, then send 8'h5A.
  - Exactly one 1-cycle `frame_err` pulse, and 8'h3C is not stored.
  - 8'h5A is then stored, with `data_count`=1.
- Overrun: send 8'h01 to 8'h05 back-to-back with no reads.
  - `full`=1 after the 4th byte.
  - A single `overrun` pulse on the 5th byte.
  - Draining yields 01, 02, 03, 04, then `empty`=1 and `dout`=8'h00.
- Push and pop while full:
  - Set-up: `data_count` is 4 holding 01..04; assert `rd_en` on the 5th byte's push edge.
  - Response: no `overrun`, and `data_count` stays at 4.
  - Draining yields 02, 03, 04, 05.
- Reset mid-frame: pull `rst_n` low during data bit 3 of a frame, with one byte already buffered.
  - All outputs take their reset values asynchronously.
  - After release with `RX` high, the next frame, 8'hC3, is received as the only byte.

Source files
------------

// File: rtl/serial_receiver_if.sv
// Read-side handshake and RX pin bundle for serial_receiver.
// The slave modport belongs to the receiver. The master modport belongs to the byte consumer.
interface serial_receiver_if #(
  parameter int DEPTH = 512
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_rx;
  logic          i_rd_en;
  logic [7:0]    o_dout;
  logic          o_valid;
  logic          o_empty;
  logic          o_full;
  logic [CW-1:0] o_data_count;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_rx_busy;

  modport slave (
    input  i_rx, i_rd_en,
    output o_dout, o_valid, o_empty, o_full, o_data_count,
           o_frame_err, o_overrun, o_rx_busy
  );

  modport master (
    output i_rx, i_rd_en,
    input  o_dout, o_valid, o_empty, o_full, o_data_count,
           o_frame_err, o_overrun, o_rx_busy
  );
endinterface

// File: rtl/serial_receiver.sv
// 8N1 UART receiver with byte FIFO; read side matches the transmitter FIFO handshake.
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, confirm start bit or reject glitch
// DATA   | sample 8 data bits LSB first
// STOP   | sample stop bit, push / overrun / frame error
// BREAK  | stop bit was low, wait for line to return high
module serial_receiver #(
  parameter int CLK_IN = 0,
  parameter int BAUD   = 0,
  parameter int DEPTH  = 512
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_receiver_if.slave bus
);

  localparam int BIT_CYCLES  = (BAUD > 0) ? (CLK_IN / BAUD) : 4;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int AW          = $clog2(DEPTH);
  localparam int CW          = AW + 1;

  localparam logic [15:0]   BIT_TGT  = 16'(BIT_CYCLES - 1);
  localparam logic [15:0]   HALF_TGT = 16'(HALF_CYCLES - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_rx_m;
  logic          r_rx_s;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overrun;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [15:0]   w_target;
  logic          w_timed;
  logic          w_sample;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_fe_set;
  logic          w_ovr_set;
  logic          w_rx_busy;
  logic          w_stop_ok;

  // Two-flop synchroniser; idle-high reset so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= bus.i_rx;
      r_rx_s <= r_rx_m;
    end
  end

  assign w_target = (r_state == S_START) ? HALF_TGT : BIT_TGT;
  assign w_timed  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_sample = w_timed && (r_cnt == w_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_next = S_START;
      S_START: if (w_sample) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_sample && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_sample) w_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_busy = (r_state != S_IDLE);
    w_pop     = bus.i_rd_en && !w_empty;
    w_stop_ok = (r_state == S_STOP) && w_sample && r_rx_s;
    w_fe_set  = (r_state == S_STOP) && w_sample && !r_rx_s;
    w_push    = w_stop_ok && (!w_full || w_pop);
    w_ovr_set = w_stop_ok && !w_push;
  end

  // Counter restarts on every state entry and at each sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if ((w_next != r_state) || w_sample || !w_timed) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 16'd1;

      if ((r_state == S_START) && w_sample)     r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_sample) r_bit_idx <= r_bit_idx + 3'd1;

      if ((r_state == S_DATA) && w_sample) r_shift[r_bit_idx] <= r_rx_s;

      r_frame_err <= w_fe_set;
      r_overrun   <= w_ovr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  assign bus.o_dout       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.o_valid      = !w_empty;
  assign bus.o_empty      = w_empty;
  assign bus.o_full       = w_full;
  assign bus.o_data_count = r_count;
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_rx_busy    = w_rx_busy;

endmodule
